// File: rtl/axis_kernel_env_port.sv
// AXI-Stream test environment port: sources a counting frame into a kernel, sinks its output, watchdogs progress.
// Optional data checker is built only when AXIS_ENV_CHECK_EN is defined.
module axis_kernel_env_port #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SEED    = '0,
  parameter int                TIMEOUT = 1024
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              start,
  input  logic [15:0]       frame_len,
  input  logic [7:0]        src_stall_mask,
  input  logic [7:0]        snk_stall_mask,
  output logic [DATA_W-1:0] in_tdata,
  output logic              in_tvalid,
  output logic              in_tlast,
  input  logic              in_tready,
  input  logic [DATA_W-1:0] out_tdata,
  input  logic              out_tvalid,
  input  logic              out_tlast,
  output logic              out_tready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rx_count,
  output logic [15:0]       err_count,
  output logic              block
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] tx_idx_q, tx_idx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] wd_q, wd_d;
  logic [2:0]  phase_q, phase_d;
  logic        pend_q, pend_d;
  logic        block_q, block_d;
  logic        done_q, done_d;

  logic accept, src_xfer, snk_xfer;

  assign busy       = (state_q != IDLE);
  assign accept     = (state_q == IDLE) && start && (frame_len != 16'd0);
  // A pending beat keeps in_tvalid up regardless of the stall mask.
  assign in_tvalid  = (state_q == RUN) && (tx_idx_q < len_q) &&
                      (pend_q || !src_stall_mask[phase_q]);
  assign in_tdata   = in_tvalid ? SEED + DATA_W'(tx_idx_q) : '0;
  assign in_tlast   = in_tvalid && (tx_idx_q == len_q - 16'd1);
  assign out_tready = busy && !snk_stall_mask[phase_q];
  assign src_xfer   = in_tvalid && in_tready;
  assign snk_xfer   = out_tvalid && out_tready;
  assign done       = done_q;
  assign rx_count   = rx_q;
  assign block      = block_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d  = state_q;
    len_d    = len_q;
    tx_idx_d = tx_idx_q;
    rx_d     = rx_q;
    wd_d     = wd_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    block_d  = block_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          len_d    = frame_len;
          tx_idx_d = '0;
          rx_d     = '0;
          wd_d     = '0;
          phase_d  = '0;
          pend_d   = 1'b0;
          block_d  = 1'b0;
        end
      end
      RUN, DRAIN: begin
        phase_d = phase_q + 3'd1;
        pend_d  = in_tvalid && !in_tready;
        if (src_xfer) tx_idx_d = tx_idx_q + 16'd1;
        if (snk_xfer && rx_q != 16'hFFFF) rx_d = rx_q + 16'd1;

        if (src_xfer || snk_xfer) begin
          wd_d = '0;
        end else if (wd_q != 16'hFFFF) begin
          wd_d = wd_q + 16'd1;
          if (wd_q == WD_LIMIT) block_d = 1'b1;
        end

        // Sink tlast ends the frame from either state, even alongside the last source beat.
        if (snk_xfer && out_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (state_q == RUN && src_xfer && in_tlast) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      tx_idx_q <= '0;
      rx_q     <= '0;
      wd_q     <= '0;
      phase_q  <= '0;
      pend_q   <= 1'b0;
      block_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent within the edge.
      state_q  <= state_d;
      len_q    <= len_d;
      tx_idx_q <= tx_idx_d;
      rx_q     <= rx_d;
      wd_q     <= wd_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      block_q  <= block_d;
      done_q   <= done_d;
    end
  end

`ifdef AXIS_ENV_CHECK_EN
  logic [15:0]       err_q, err_d;
  logic [DATA_W-1:0] exp_data;

  // Expected value uses the count before this beat is added.
  assign exp_data = SEED + DATA_W'(rx_q);

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = '0;
    end else if (snk_xfer && (out_tdata != exp_data) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) err_q <= '0;
    else                      err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_sink_data;
  assign unused_sink_data = ^out_tdata;
  assign err_count        = '0;
`endif

endmodule

// File: tb/tb_axis_kernel_env_port.sv
// Directed bench for axis_kernel_env_port: flow-through loopback kernel plus a manually driven kernel mode.
module tb_axis_kernel_env_port;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic [7:0]  src_stall_mask, snk_stall_mask;
  logic [31:0] in_tdata, out_tdata;
  logic        in_tvalid, in_tlast, in_tready;
  logic        out_tvalid, out_tlast, out_tready;
  logic        busy, done, block;
  logic [15:0] rx_count, err_count;

  // kernel model controls: mode 0 = flow-through loopback, mode 1 = manual
  logic        k_mode, k_en, k_corrupt;
  logic        m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] beat_data[$];
  logic        beat_last[$];
  int          done_seen;
  int          stab_err;
  logic        prev_pend;
  logic [31:0] prev_data;
  logic [31:0] held_data;

  axis_kernel_env_port #(.DATA_W(32), .SEED(32'h0), .TIMEOUT(16)) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .start                (start),
    .frame_len            (frame_len),
    .src_stall_mask       (src_stall_mask),
    .snk_stall_mask       (snk_stall_mask),
    .in_tdata             (in_tdata),
    .in_tvalid            (in_tvalid),
    .in_tlast             (in_tlast),
    .in_tready            (in_tready),
    .out_tdata            (out_tdata),
    .out_tvalid           (out_tvalid),
    .out_tlast            (out_tlast),
    .out_tready           (out_tready),
    .busy                 (busy),
    .done                 (done),
    .rx_count             (rx_count),
    .err_count            (err_count),
    .block                (block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (k_mode == 1'b0) begin
      in_tready  = out_tready & k_en;
      out_tvalid = in_tvalid & k_en;
      out_tdata  = (k_corrupt && in_tdata == 32'd2) ? 32'hDEAD : in_tdata;
      out_tlast  = in_tlast;
    end else begin
      in_tready  = m_tready;
      out_tvalid = m_tvalid;
      out_tdata  = m_tdata;
      out_tlast  = m_tlast;
    end
  end

  // Mid-cycle monitor: source beats, done pulses, and pending-beat stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend && (!in_tvalid || in_tdata != prev_data)) stab_err++;
      if (in_tvalid && in_tready) begin
        beat_data.push_back(in_tdata);
        beat_last.push_back(in_tlast);
      end
      prev_pend = in_tvalid && !in_tready;
      prev_data = in_tdata;
      if (done) done_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_data.delete();
    beat_last.delete();
    done_seen = 0;
    stab_err  = 0;
  endtask

  task automatic do_start(input logic [15:0] len);
    frame_len = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int len);
    check({tag, "_beats"}, beat_data.size(), len);
    for (int i = 0; i < beat_data.size(); i++) begin
      check({tag, "_data"}, beat_data[i], i);
      check({tag, "_last"}, beat_last[i], (i == len - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_len = '0;
    src_stall_mask = '0; snk_stall_mask = '0;
    k_mode = 1'b0; k_en = 1'b1; k_corrupt = 1'b0;
    m_tready = 1'b0; m_tvalid = 1'b0; m_tlast = 1'b0; m_tdata = '0;
    done_seen = 0; stab_err = 0; prev_pend = 1'b0; prev_data = '0; held_data = '0;

    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_tvalid", in_tvalid, 1'b0);
    check("rst_tdata", in_tdata, 32'h0);
    check("rst_tlast", in_tlast, 1'b0);
    check("rst_tready", out_tready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_count, 16'h0);
    check("rst_block", block, 1'b0);
    rst = 1'b0;
    tick();

    // zero-length start is ignored
    do_start(16'd0);
    check("len0_busy", busy, 1'b0);

    // basic loopback frame of 4
    clear_mon();
    do_start(16'd4);
    check("b_busy", busy, 1'b1);
    wait_done("b_done", 20);
    check("b_rx", rx_count, 16'd4);
    repeat (3) tick();
    check_frame("b", 4);
    check("b_done_cnt", done_seen, 1);
    check("b_err", err_count, 16'd0);
    check("b_idle", busy, 1'b0);

    // source stall mask plus a 5-cycle in_tready hold on beat 2
    src_stall_mask = 8'hAA;
    clear_mon();
    do_start(16'd4);
    for (int n = 0; n < 16 && !(in_tvalid && in_tdata == 32'd2); n++) tick();
    check("c_beat2_valid", in_tvalid, 1'b1);
    k_en = 1'b0;
    held_data = in_tdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_hold_valid", in_tvalid, 1'b1);
      check("c_hold_data", in_tdata, held_data);
    end
    k_en = 1'b1;
    wait_done("c_done", 40);
    repeat (2) tick();
    check_frame("c", 4);
    check("c_stable", stab_err, 0);
    check("c_done_cnt", done_seen, 1);
    check("c_rx", rx_count, 16'd4);
    src_stall_mask = 8'h00;

    // watchdog: no progress from either side
    k_en = 1'b0;
    clear_mon();
    do_start(16'd4);
    repeat (15) tick();
    check("d_block_early", block, 1'b0);
    tick();
    check("d_block_set", block, 1'b1);
    repeat (5) tick();
    check("d_block_sticky", block, 1'b1);
    check("d_still_busy", busy, 1'b1);
    k_en = 1'b1;
    wait_done("d_done", 20);
    tick();
    check("d_block_idle", block, 1'b1);
    do_start(16'd2);
    check("d_block_clear", block, 1'b0);
    wait_done("d_done2", 20);
    tick();

    // kernel corrupts beat 2
    k_corrupt = 1'b1;
    clear_mon();
    do_start(16'd4);
    wait_done("e_done", 20);
`ifdef AXIS_ENV_CHECK_EN
    check("e_err", err_count, 16'd1);
`else
    check("e_err", err_count, 16'd0);
`endif
    check("e_rx", rx_count, 16'd4);
    k_corrupt = 1'b0;
    tick();

    // reset during beat 2 of 8
    clear_mon();
    do_start(16'd8);
    tick(); tick();
    check("f_beat2", in_tdata, 32'd2);
    #3 rst = 1'b1;
    #1;
    check("f_rst_busy", busy, 1'b0);
    check("f_rst_tvalid", in_tvalid, 1'b0);
    check("f_rst_tdata", in_tdata, 32'h0);
    check("f_rst_tready", out_tready, 1'b0);
    check("f_rst_rx", rx_count, 16'h0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    check("f_no_done", done_seen, 0);
    check("f_idle", busy, 1'b0);
    clear_mon();
    do_start(16'd3);
    wait_done("f_done", 20);
    repeat (2) tick();
    check_frame("f", 3);
    check("f_done_cnt", done_seen, 1);
    check("f_rx", rx_count, 16'd3);

    // single-beat frame, same-cycle return; start while busy is ignored
    clear_mon();
    do_start(16'd1);
    check("g_tlast", in_tlast, 1'b1);
    check("g_snk_xfer", out_tvalid && out_tready, 1'b1);
    frame_len = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g_done", done, 1'b1);
    check("g_idle", busy, 1'b0);
    check("g_rx", rx_count, 16'd1);
    tick();
    check("g_done_off", done, 1'b0);
    check("g_no_restart", busy, 1'b0);

    // DRAIN: source finishes before the kernel returns anything
    k_mode = 1'b1;
    m_tready = 1'b1;
    clear_mon();
    do_start(16'd2);
    tick(); tick();
    check("h_drain_busy", busy, 1'b1);
    check("h_drain_tvalid", in_tvalid, 1'b0);
    snk_stall_mask = 8'hFF;
    #1;
    check("h_snk_stall", out_tready, 1'b0);
    snk_stall_mask = 8'h00;
    #1;
    check("h_snk_ready", out_tready, 1'b1);
    m_tvalid = 1'b1; m_tdata = 32'd0; m_tlast = 1'b0;
    tick();
    check("h_mid_done", done, 1'b0);
    m_tdata = 32'd1; m_tlast = 1'b1;
    tick();
    m_tvalid = 1'b0; m_tlast = 1'b0;
    check("h_done", done, 1'b1);
    check("h_idle", busy, 1'b0);
    check("h_rx", rx_count, 16'd2);
    check("h_err", err_count, 16'd0);
    k_mode = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_kernel_env_port.md
AXIS_KERNEL_ENV_PORT -- requirements
Module: axis_kernel_env_port

Interface
REQ-001 DATA_W, 32, width of the stream data on both ports.
REQ-002 SEED, 32'h0, value of source beat 0; beat k carries SEED+k, modulo 2^DATA_W.
REQ-003 TIMEOUT, 1024, number of no-progress cycles before block asserts; legal range 2..65535.
REQ-004 kernel_monitor_clock  in  1  single clock; all state on the rising edge.
REQ-005 kernel_monitor_reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run one frame; sampled only in IDLE.
REQ-007 frame_len  in  16  beats per frame; sampled when start is accepted.
REQ-008 src_stall_mask / snk_stall_mask  in  8 each  per-phase stall patterns.
REQ-009 in_tdata / in_tvalid / in_tlast  out  DATA_W/1/1  source side, drives the kernel inStream.
REQ-010 in_tready  in  1  kernel inStream ready.
REQ-011 out_tdata / out_tvalid / out_tlast  in  DATA_W/1/1  kernel outStream.
REQ-012 out_tready  out  1  sink ready toward the kernel outStream.
REQ-013 busy / done  out  1/1  frame in progress; one-cycle completion pulse.
REQ-014 rx_count  out  16  outStream beats accepted in the current frame.
REQ-015 err_count  out  16  data mismatches (checker only, see Configuration).
REQ-016 block  out  1  sticky flag: no transfer on either port for TIMEOUT cycles.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN on start=1 with frame_len!=0; frame_len latched; tx and rx counters, err_count and block cleared.
REQ-019 start with frame_len=0, or start in RUN/DRAIN, is ignored.
REQ-020 busy=1 in RUN and DRAIN.
REQ-021 A 3-bit phase counter advances every cycle while busy=1 and resets to 0 on frame accept.
REQ-022 Source: in_tvalid asserts in RUN when tx_idx<frame_len and src_stall_mask[phase]=0.
REQ-023 Once asserted, in_tvalid, in_tdata and in_tlast hold stable until the in_tvalid&in_tready cycle; the stall mask never drops a pending beat.
REQ-024 in_tdata=SEED+tx_idx; in_tlast=1 exactly on tx_idx=frame_len-1.
REQ-025 RUN -> DRAIN on the cycle the last source beat transfers.
REQ-026 Sink: out_tready = busy & ~snk_stall_mask[phase]; out_tready may drop without a pending-beat restriction.
REQ-027 Each out_tvalid&out_tready cycle increments rx_count, saturating at 16'hFFFF.
REQ-028 A sink transfer with out_tlast=1 raises done for one cycle on the following cycle and returns the FSM to IDLE, from RUN or DRAIN; rx_count and err_count hold until the next accepted start.
REQ-029 Simultaneous last source beat and sink tlast in one cycle: both transfers count, and the FSM goes directly to IDLE.
REQ-030 Watchdog: a 16-bit counter increments while busy with no transfer on either port, and clears on any transfer.
REQ-031 block sets when the watchdog counter reaches TIMEOUT-1 and increments; block stays set until an accepted start or reset.
REQ-032 block does not stop the FSM.

Reset
REQ-033 Asynchronous assert: FSM=IDLE, in_tvalid=0, in_tlast=0, in_tdata=0, out_tready=0, busy=0, done=0, rx_count=0, err_count=0, block=0, all counters 0.
REQ-034 Reset asserted mid-frame abandons the frame with no done pulse.
REQ-035 The first start is accepted no earlier than the first clock edge after reset deasserts.

Configuration
REQ-036 AXIS_ENV_CHECK_EN defined: each sink beat compares out_tdata against SEED+rx_count, using the pre-increment count.
REQ-037 With AXIS_ENV_CHECK_EN defined, each mismatching beat increments err_count, saturating at 16'hFFFF.
REQ-038 AXIS_ENV_CHECK_EN undefined: the comparator is not built and err_count is tied to 0.

Verification
REQ-039 Loopback kernel, frame_len=4, SEED=0, both masks 0 -> in_tdata 0,1,2,3 with tlast on 3; rx_count=4; done pulse once; err_count=0.
REQ-040 src_stall_mask=8'hAA, in_tready held 0 for 5 cycles mid-beat -> in_tvalid and in_tdata stable throughout; all beats delivered exactly once.
REQ-041 TIMEOUT=16, in_tready=0 and out_tvalid=0 after start -> block=1 exactly 16 cycles later; block stays set; the next start clears it.
REQ-042 Kernel returns beat 2 as 32'hDEAD with AXIS_ENV_CHECK_EN defined -> err_count=1 after done; with the macro undefined -> err_count=0.
REQ-043 Reset pulse during beat 2 of 8 -> all outputs at reset values immediately; no done pulse; a new start runs a clean frame.
REQ-044 frame_len=1 with the kernel accepting the beat and returning tlast in the same cycle -> done on the next cycle; FSM goes directly to IDLE; start while busy ignored.
